// File: rtl/sdram_ram_arbiter.sv
// Multi-port round-robin arbiter in front of an SDRAM core, with burst write
// locking and an in-order response-routing FIFO. Request and response paths
// are purely combinational, so the arbiter adds no cycles of latency.
// Optional build macro: SDRAM_ARB_QOS_EN gives a requesting port 0 priority
// in every unlocked arbitration.
module sdram_ram_arbiter #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned LEN_W       = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_PORTS*32-1:0]      in_addr_i,
  input  logic [NUM_PORTS*4-1:0]       in_wr_i,
  input  logic [NUM_PORTS-1:0]         in_rd_i,
  input  logic [NUM_PORTS*LEN_W-1:0]   in_len_i,
  input  logic [NUM_PORTS*32-1:0]      in_wdata_i,
  output logic [NUM_PORTS-1:0]         in_accept_o,
  output logic [NUM_PORTS-1:0]         in_ack_o,
  output logic                         in_error_o,
  output logic [31:0]                  in_read_data_o,
  output logic [31:0]                  ram_addr_o,
  output logic [3:0]                   ram_wr_o,
  output logic                         ram_rd_o,
  output logic [LEN_W-1:0]             ram_len_o,
  output logic [31:0]                  ram_write_data_o,
  input  logic                         ram_accept_i,
  input  logic                         ram_ack_i,
  input  logic                         ram_error_i,
  input  logic [31:0]                  ram_read_data_i
);

  localparam int unsigned PW  = $clog2(NUM_PORTS);
  localparam int unsigned PW1 = PW + 1;
  localparam int unsigned AW  = $clog2(OUTSTANDING);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned BW  = LEN_W + 1;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] wr_req;
  logic [PW-1:0]        rr_ptr_q;
  logic                 lock_q;
  logic [PW-1:0]        lock_port_q;
  logic [LEN_W-1:0]     lock_cnt_q;
  logic [PW-1:0]        fifo_port_q  [OUTSTANDING];
  logic [BW-1:0]        fifo_beats_q [OUTSTANDING];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic [BW-1:0]        beat_cnt_q;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 gnt_valid;
  logic [PW-1:0]        gnt_idx;
  logic                 gnt_is_wr;
  logic                 accept;
  logic                 ack_hit;
  logic                 pop;
  logic [PW-1:0]        head_port;
  logic [BW-1:0]        head_beats;
  logic [PW:0]          cand;

  // Select bit idx of a per-port vector without an out-of-range index.
  function automatic logic bit_at(input logic [NUM_PORTS-1:0] v, input logic [PW-1:0] idx);
    logic r;
    r = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (idx == PW'(p)) r = v[p];
    end
    return r;
  endfunction

  // Per-port request decode; any write strobe makes it a write.
  always_comb begin
    wr_req = '0;
    req    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_req[p] = |in_wr_i[p*4 +: 4];
      req[p]    = wr_req[p] | in_rd_i[p];
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(OUTSTANDING));

  // Grant selection: held lock first, otherwise round-robin from the pointer.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (!fifo_full) begin
      if (lock_q) begin
        gnt_valid = bit_at(req, lock_port_q);
        gnt_idx   = lock_port_q;
      end
`ifdef SDRAM_ARB_QOS_EN
      else if (req[0]) begin
        gnt_valid = 1'b1;
        gnt_idx   = '0;
      end
`endif
      else begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          cand = {1'b0, rr_ptr_q} + PW1'(i);
          if (cand >= PW1'(NUM_PORTS)) cand = cand - PW1'(NUM_PORTS);
          if (!gnt_valid && bit_at(req, cand[PW-1:0])) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand[PW-1:0];
          end
        end
      end
    end
  end

  assign accept = ram_accept_i & gnt_valid;

  // Core request mux and per-port accept strobes; all zero without a grant.
  always_comb begin
    ram_addr_o       = '0;
    ram_wr_o         = '0;
    ram_rd_o         = 1'b0;
    ram_len_o        = '0;
    ram_write_data_o = '0;
    in_accept_o      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_valid && gnt_idx == PW'(p)) begin
        ram_addr_o       = in_addr_i[p*32 +: 32];
        ram_wr_o         = in_wr_i[p*4 +: 4];
        ram_rd_o         = in_rd_i[p] & ~wr_req[p];
        ram_len_o        = in_len_i[p*LEN_W +: LEN_W];
        ram_write_data_o = in_wdata_i[p*32 +: 32];
        in_accept_o[p]   = ram_accept_i;
      end
    end
  end

  assign gnt_is_wr = |ram_wr_o;

  assign head_port  = fifo_port_q[rd_ptr_q];
  assign head_beats = fifo_beats_q[rd_ptr_q];
  assign ack_hit    = ram_ack_i & ~fifo_empty;
  assign pop        = ack_hit && ((beat_cnt_q + BW'(1)) == head_beats);

  // Response routing to the head port; data and error go straight through.
  always_comb begin
    in_ack_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_ack_o[p] = ack_hit && (head_port == PW'(p));
    end
  end

  assign in_error_o     = ram_error_i;
  assign in_read_data_o = ram_read_data_i;

  // Round-robin pointer and burst write lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_port_q <= '0;
      lock_cnt_q  <= '0;
    end else if (accept) begin
      if (lock_q) begin
        lock_cnt_q <= lock_cnt_q - LEN_W'(1);
        if (lock_cnt_q == LEN_W'(1)) lock_q <= 1'b0;
      end else begin
        rr_ptr_q <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
        if (gnt_is_wr && (ram_len_o != '0)) begin
          lock_q      <= 1'b1;
          lock_port_q <= gnt_idx;
          lock_cnt_q  <= ram_len_o;
        end
      end
    end
  end

  // Routing FIFO payload: owning port and expected response beats.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_port_q[wr_ptr_q]  <= gnt_idx;
      fifo_beats_q[wr_ptr_q] <= gnt_is_wr ? BW'(1) : BW'(ram_len_o) + BW'(1);
    end
  end

  // Routing FIFO pointers, occupancy and head beat counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({accept, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (ack_hit) beat_cnt_q <= pop ? '0 : beat_cnt_q + BW'(1);
    end
  end

endmodule

// File: tb/tb_sdram_ram_arbiter.sv
// Randomised and directed bench for sdram_ram_arbiter against a queue-based
// transaction model of the arbitration and response-routing rules.
module tb_sdram_ram_arbiter;

  localparam int N   = 3;
  localparam int OUT = 4;
  localparam int LW  = 8;
  localparam int OW  = 2*N + 1 + 32 + 32 + 4 + 1 + LW + 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*32-1:0] in_addr;
  logic [N*4-1:0]  in_wr;
  logic [N-1:0]    in_rd;
  logic [N*LW-1:0] in_len;
  logic [N*32-1:0] in_wdata;
  logic [N-1:0]    in_accept;
  logic [N-1:0]    in_ack;
  logic            in_error;
  logic [31:0]     in_rdata;
  logic [31:0]     ram_addr;
  logic [3:0]      ram_wr;
  logic            ram_rd;
  logic [LW-1:0]   ram_len;
  logic [31:0]     ram_wdata;
  logic            ram_accept;
  logic            ram_ack;
  logic            ram_error;
  logic [31:0]     ram_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {int port; int beats;} ent_t;
  ent_t m_q[$];
  int   m_ptr;
  int   m_lock_port;
  int   m_lock_left;
  int   m_beat;

  always #5 clk = ~clk;

  sdram_ram_arbiter #(.NUM_PORTS(N), .OUTSTANDING(OUT), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_addr_i(in_addr), .in_wr_i(in_wr), .in_rd_i(in_rd), .in_len_i(in_len),
    .in_wdata_i(in_wdata), .in_accept_o(in_accept), .in_ack_o(in_ack),
    .in_error_o(in_error), .in_read_data_o(in_rdata),
    .ram_addr_o(ram_addr), .ram_wr_o(ram_wr), .ram_rd_o(ram_rd), .ram_len_o(ram_len),
    .ram_write_data_o(ram_wdata), .ram_accept_i(ram_accept), .ram_ack_i(ram_ack),
    .ram_error_i(ram_error), .ram_read_data_i(ram_rdata)
  );

  function automatic bit is_req(input int p);
    return (in_wr[p*4 +: 4] != 4'h0) || in_rd[p];
  endfunction

  // Model: which port the arbiter should grant with the current inputs.
  function automatic int pred_grant();
    int g;
    g = -1;
    if (m_q.size() < OUT) begin
      if (m_lock_port >= 0) begin
        if (is_req(m_lock_port)) g = m_lock_port;
      end else begin
`ifdef SDRAM_ARB_QOS_EN
        if (is_req(0)) g = 0;
`endif
        for (int i = 0; i < N; i++) begin
          if (g < 0 && is_req((m_ptr + i) % N)) g = (m_ptr + i) % N;
        end
      end
    end
    return g;
  endfunction

  function automatic logic [OW-1:0] predict();
    int g;
    logic [N-1:0] acc, ack;
    logic [31:0] a, wd;
    logic [3:0] w;
    logic r;
    logic [LW-1:0] l;
    g = pred_grant();
    acc = '0; ack = '0; a = '0; wd = '0; w = '0; r = 1'b0; l = '0;
    if (g >= 0) begin
      a  = in_addr[g*32 +: 32];
      w  = in_wr[g*4 +: 4];
      r  = in_rd[g] && (w == 4'h0);
      l  = in_len[g*LW +: LW];
      wd = in_wdata[g*32 +: 32];
      if (ram_accept) acc[g] = 1'b1;
    end
    if (ram_ack && m_q.size() > 0) ack[m_q[0].port] = 1'b1;
    return {acc, ack, ram_error, ram_rdata, a, w, r, l, wd};
  endfunction

  function automatic logic [OW-1:0] obs_vec();
    return {in_accept, in_ack, in_error, in_rdata, ram_addr, ram_wr, ram_rd, ram_len, ram_wdata};
  endfunction

  task automatic m_clear();
    m_q.delete();
    m_ptr = 0; m_lock_port = -1; m_lock_left = 0; m_beat = 0;
  endtask

  // Model: state change at the coming rising edge.
  task automatic advance();
    int g, l;
    bit w;
    g = pred_grant();
    if (!rst_n) begin
      m_clear();
      return;
    end
    if (ram_ack && m_q.size() > 0) begin
      m_beat++;
      if (m_beat == m_q[0].beats) begin
        m_q.delete(0);
        m_beat = 0;
      end
    end
    if (ram_accept && g >= 0) begin
      w = (in_wr[g*4 +: 4] != 4'h0);
      l = int'(in_len[g*LW +: LW]);
      if (m_lock_port >= 0) begin
        m_lock_left--;
        if (m_lock_left == 0) m_lock_port = -1;
      end else begin
        m_ptr = (g + 1) % N;
        if (w && l > 0) begin
          m_lock_port = g;
          m_lock_left = l;
        end
      end
      m_q.push_back('{g, w ? 1 : l + 1});
    end
  endtask

  task automatic clear_inputs();
    in_addr = '0; in_wr = '0; in_rd = '0; in_len = '0; in_wdata = '0;
    ram_accept = 1'b0; ram_ack = 1'b0; ram_error = 1'b0; ram_rdata = '0;
  endtask

  task automatic set_port(input int p, input bit rd, input logic [3:0] wr, input int len);
    in_rd[p]           = rd;
    in_wr[p*4 +: 4]    = wr;
    in_len[p*LW +: LW] = LW'(len);
    in_addr[p*32 +: 32]  = $urandom;
    in_wdata[p*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Shared per-cycle stimulus for response beats.
  task automatic drive_resp(input bit ack);
    ram_ack   = ack;
    ram_error = 1'($urandom_range(0, 1));
    ram_rdata = $urandom;
  endtask

  task automatic test_reset();
    logic [OW-1:0] o;
    clear_inputs();
    rst_n = 1'b0;
    m_clear();
    ram_ack = 1'b1;
    @(negedge clk);
    o = obs_vec();
    checks++;
    if (o !== '0) begin failures++; $display("FAIL reset_hold got=%h exp=0", o); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    o = obs_vec();
    checks++;
    if (o !== '0) begin failures++; $display("FAIL reset_release got=%h exp=0", o); end
    advance();
    @(posedge clk); #1;
  endtask

  task automatic test_alternate();
    logic [OW-1:0] e;
    int n0, n1;
    logic [N-1:0] exp_acc;
    do_reset();
    n0 = 0; n1 = 0;
    for (int k = 0; k < 13; k++) begin
      clear_inputs();
      if (k < 12) begin
        set_port(0, 1'b1, 4'h0, 0);
        set_port(1, 1'b1, 4'h0, 0);
      end
      ram_accept = 1'b1;
      drive_resp(1'b1);
      @(negedge clk);
      e = predict();
      checks++;
      if (obs_vec() !== e) begin failures++; $display("FAIL alt_model cyc=%0d got=%h exp=%h", k, obs_vec(), e); end
      if (k < 12) begin
        exp_acc = (k % 2 == 0) ? 3'b001 : 3'b010;
        checks++;
        if (in_accept !== exp_acc) begin failures++; $display("FAIL alt_grant cyc=%0d got=%b exp=%b", k, in_accept, exp_acc); end
      end
      if (in_ack[0] === 1'b1) n0++;
      if (in_ack[1] === 1'b1) n1++;
      advance();
      @(posedge clk); #1;
    end
    checks++;
    if (n0 != 6 || n1 != 6) begin failures++; $display("FAIL alt_ack_count got=%0d/%0d exp=6/6", n0, n1); end
  endtask

  task automatic test_lock();
    logic [OW-1:0] e;
    logic [N-1:0] seq [6];
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b010;
    seq[3] = 3'b010; seq[4] = 3'b010; seq[5] = 3'b001;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      clear_inputs();
      set_port(0, 1'b1, 4'h0, 0);
      set_port(1, 1'b0, 4'hF, 3);
      ram_accept = 1'b1;
      drive_resp(1'b1);
      @(negedge clk);
      e = predict();
      checks++;
      if (obs_vec() !== e) begin failures++; $display("FAIL lock_model cyc=%0d got=%h exp=%h", k, obs_vec(), e); end
      checks++;
      if (in_accept !== seq[k]) begin failures++; $display("FAIL lock_grant cyc=%0d got=%b exp=%b", k, in_accept, seq[k]); end
      advance();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full();
    logic [OW-1:0] e;
    logic [N-1:0] exp_acc;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      clear_inputs();
      set_port(0, 1'b1, 4'h0, 0);
      ram_accept = 1'b1;
      drive_resp(k >= 5);
      @(negedge clk);
      e = predict();
      checks++;
      if (obs_vec() !== e) begin failures++; $display("FAIL full_model cyc=%0d got=%h exp=%h", k, obs_vec(), e); end
      exp_acc = (k < 4 || k == 6) ? 3'b001 : 3'b000;
      checks++;
      if (in_accept !== exp_acc) begin failures++; $display("FAIL full_accept cyc=%0d got=%b exp=%b", k, in_accept, exp_acc); end
      advance();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_routing();
    logic [OW-1:0] e;
    logic [N-1:0] exp_ack;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      clear_inputs();
      if (k == 0) set_port(0, 1'b1, 4'h0, 2);
      if (k == 1) set_port(1, 1'b1, 4'h0, 0);
      ram_accept = 1'b1;
      drive_resp(k >= 2);
      @(negedge clk);
      e = predict();
      checks++;
      if (obs_vec() !== e) begin failures++; $display("FAIL route_model cyc=%0d got=%h exp=%h", k, obs_vec(), e); end
      exp_ack = (k < 2) ? 3'b000 : (k < 5) ? 3'b001 : 3'b010;
      checks++;
      if (in_ack !== exp_ack || in_rdata !== ram_rdata) begin
        failures++;
        $display("FAIL route_ack cyc=%0d got=%b/%h exp=%b/%h", k, in_ack, in_rdata, exp_ack, ram_rdata);
      end
      advance();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] e;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      clear_inputs();
      if (k == 0) set_port(0, 1'b1, 4'h0, 3);
      ram_accept = 1'b1;
      drive_resp(k == 1);
      @(negedge clk);
      e = predict();
      checks++;
      if (obs_vec() !== e) begin failures++; $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", k, obs_vec(), e); end
      advance();
      @(posedge clk); #1;
    end
    clear_inputs();
    rst_n = 1'b0;
    m_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_inputs();
    drive_resp(1'b1);
    @(negedge clk);
    checks++;
    if (in_ack !== 3'b000) begin failures++; $display("FAIL rstmid_stray_ack got=%b exp=000", in_ack); end
    advance();
    @(posedge clk); #1;
    clear_inputs();
    set_port(0, 1'b1, 4'h0, 0);
    set_port(1, 1'b1, 4'h0, 0);
    ram_accept = 1'b1;
    @(negedge clk);
    checks++;
    if (in_accept !== 3'b001) begin failures++; $display("FAIL rstmid_regrant got=%b exp=001", in_accept); end
    advance();
    @(posedge clk); #1;
  endtask

`ifdef SDRAM_ARB_QOS_EN
  task automatic test_qos();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      clear_inputs();
      set_port(0, 1'b1, 4'h0, 0);
      set_port(2, 1'b1, 4'h0, 0);
      ram_accept = 1'b1;
      drive_resp(1'b1);
      @(negedge clk);
      checks++;
      if (in_accept !== 3'b001) begin failures++; $display("FAIL qos_grant cyc=%0d got=%b exp=001", k, in_accept); end
      advance();
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic test_random();
    logic [OW-1:0] e;
    int mode;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      clear_inputs();
      for (int p = 0; p < N; p++) begin
        mode = $urandom_range(0, 3);
        set_port(p, mode[0], (mode[1]) ? 4'($urandom_range(1, 15)) : 4'h0, $urandom_range(0, 3));
      end
      ram_accept = ($urandom_range(0, 3) != 0);
      drive_resp($urandom_range(0, 1) == 1);
      @(negedge clk);
      e = predict();
      checks++;
      if (obs_vec() !== e) begin failures++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", k, obs_vec(), e); end
      advance();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    m_clear();
    test_reset();
    test_alternate();
    test_lock();
    test_full();
    test_routing();
    test_reset_mid();
`ifdef SDRAM_ARB_QOS_EN
    test_qos();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_ram_arbiter.md
SDRAM_RAM_ARBITER -- requirements
Module: sdram_ram_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requester ports (legal range 2..8).
REQ-002 SHALL have parameter OUTSTANDING, default 4, response-routing FIFO depth (power of 2, at least 2).
REQ-003 SHALL have parameter LEN_W, default 8, burst length field width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, declared as the first two ports below.
REQ-005 clk_i  input  1  sole clock; all state on rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 in_addr_i  input  NUM_PORTS*32  per-port byte address; port p at bits [p*32 +: 32].
REQ-008 in_wr_i  input  NUM_PORTS*4  per-port write byte strobes; non-zero means write request.
REQ-009 in_rd_i  input  NUM_PORTS  per-port read request.
REQ-010 in_len_i  input  NUM_PORTS*LEN_W  per-port burst length minus one.
REQ-011 in_wdata_i  input  NUM_PORTS*32  per-port write data.
REQ-012 in_accept_o  output  NUM_PORTS  per-port request accepted this cycle.
REQ-013 in_ack_o  output  NUM_PORTS  per-port response beat valid.
REQ-014 in_error_o  output  1  error flag of the current response beat, broadcast.
REQ-015 in_read_data_o  output  32  read data of the current response beat, broadcast.
REQ-016 ram_addr_o  output  32  address to SDRAM core.
REQ-017 ram_wr_o  output  4  write strobes to core.
REQ-018 ram_rd_o  output  1  read request to core.
REQ-019 ram_len_o  output  LEN_W  burst length to core.
REQ-020 ram_write_data_o  output  32  write data to core.
REQ-021 ram_accept_i  input  1  core accepted the presented request.
REQ-022 ram_ack_i  input  1  core response beat.
REQ-023 ram_error_i  input  1  core response error.
REQ-024 ram_read_data_i  input  32  core read data.

Function
REQ-025 A port is requesting when its in_wr_i slice is non-zero or its in_rd_i bit is set; if both, the write takes precedence.
REQ-026 The grant is combinational: the first requesting port at or after the round-robin pointer, modulo NUM_PORTS; the ram_* request outputs mux the granted port, and are 0 when there is no grant.
REQ-027 in_accept_o[g] = ram_accept_i AND grant to g; all other bits are 0.
REQ-028 On accept, the pointer SHALL become (g+1) mod NUM_PORTS, except while a lock is active.
REQ-029 An accepted write with len L>0 sets a lock to port g for L further beats; during the lock, only port g is granted, and the counter decrements per accepted beat; the lock is released when it reaches 0.
REQ-030 Every accept pushes {port, beats}, with beats = L+1 for a read and 1 for a write, into the routing FIFO.
REQ-031 No grant SHALL be issued while the FIFO holds OUTSTANDING entries, even if a pop occurs in that cycle; a lock stays held but stalls.
REQ-032 ram_ack_i asserts in_ack_o[head port] in the same cycle and increments the head beat counter; the head is popped on its last beat.
REQ-033 ram_ack_i with an empty FIFO SHALL be dropped: no in_ack_o bit is asserted.
REQ-034 in_error_o and in_read_data_o pass ram_error_i and ram_read_data_i through combinationally.
REQ-035 Latency SHALL add zero cycles in both directions.

Reset
REQ-036 While rst_ni is low: pointer = 0, lock cleared, FIFO empty, beat counter = 0.
REQ-037 With no requests asserted, all outputs SHALL be 0 during and after reset.
REQ-038 Reset mid-burst discards outstanding routing state; acks that arrive later are dropped per REQ-033.

Configuration
REQ-039 Macro SDRAM_ARB_QOS_EN: when defined, a requesting port 0 SHALL win every unlocked arbitration, with the rest round-robin; when undefined, all ports are pure round-robin per REQ-026.

Verification
REQ-040 Ports 0 and 1 issue continuous single reads, ram_accept_i always 1 -> grants alternate 0,1,0,1; each port receives one ack per read.
REQ-041 Port 1 writes with len=3 while port 0 reads -> four consecutive port-1 accepts, then port 0 is granted.
REQ-042 OUTSTANDING=4, five reads with no acks -> the fifth is not accepted until the first ack completes.
REQ-043 Port 0 reads len=2, then port 1 reads len=0 -> acks route 0,0,0,1 with data passed unchanged.
REQ-044 rst_ni is pulsed low mid-burst, then a stray ram_ack_i arrives -> no in_ack_o is asserted and grants restart at port 0.
REQ-045 With SDRAM_ARB_QOS_EN and ports 0 and 2 requesting continuously -> port 0 is granted every cycle.
